// File: rtl/q_tile_buffer_pkg.sv
// Shared types and default tile geometry for the Q-tile ping-pong buffer.
package q_tile_buffer_pkg;

    localparam int Q_VEC_W       = 16;
    localparam int DEF_Q_ROWS    = 4;
    localparam int DEF_KV_PASSES = 8;

    typedef logic [Q_VEC_W-1:0] q_vector_t;

endpackage

// File: rtl/q_tile_bank.sv
// One bank of Q-tile storage: a single write port and an asynchronous read port.
module q_tile_bank
    import q_tile_buffer_pkg::*;
#(
    parameter int  ROWS   = DEF_Q_ROWS,
    localparam int ADDR_W = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [Q_VEC_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [Q_VEC_W-1:0] rdata
);

    q_vector_t mem [ROWS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/q_tile_buffer.sv
// Ping-pong Q-tile buffer: fills one bank from the memory controller while the
// other bank is replayed KV_PASSES times to the PE array.
module q_tile_buffer
    import q_tile_buffer_pkg::*;
#(
    parameter int  Q_ROWS    = DEF_Q_ROWS,
    parameter int  KV_PASSES = DEF_KV_PASSES,
    localparam int ROW_W     = $clog2(Q_ROWS),
    localparam int PASS_W    = (KV_PASSES > 1) ? $clog2(KV_PASSES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_vld,
    input  logic [Q_VEC_W-1:0] loaded_Q_vector,
    output logic               Q_sram_rdy,
    output logic               q_vld,
    output logic [Q_VEC_W-1:0] q_vector,
    output logic [ROW_W-1:0]   q_row_idx,
    output logic [PASS_W-1:0]  q_pass_idx,
    input  logic               pe_rdy,
    output logic               tile_done
);

    logic [1:0]         bank_full;
    logic [1:0]         bank_full_next;
    logic               wr_bank;
    logic               rd_bank;
    logic [ROW_W-1:0]   wr_ptr;
    logic [ROW_W-1:0]   rd_ptr;
    logic [PASS_W-1:0]  pass_cnt;
    logic               done_q;

    logic               wr_fire;
    logic               rd_fire;
    logic               wr_last;
    logic               rd_row_last;
    logic               pass_last;
    logic               tile_free;
    logic [Q_VEC_W-1:0] rdata0;
    logic [Q_VEC_W-1:0] rdata1;

    assign Q_sram_rdy  = !bank_full[wr_bank];
    assign q_vld       = bank_full[rd_bank];
    assign wr_fire     = ctrl_vld && Q_sram_rdy;
    assign rd_fire     = q_vld && pe_rdy;
    assign wr_last     = (wr_ptr == ROW_W'(Q_ROWS - 1));
    assign rd_row_last = (rd_ptr == ROW_W'(Q_ROWS - 1));
    assign pass_last   = (pass_cnt == PASS_W'(KV_PASSES - 1));
    assign tile_free   = rd_fire && rd_row_last && pass_last;

    q_tile_bank #(.ROWS(Q_ROWS)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire && !wr_bank),
        .waddr (wr_ptr),
        .wdata (loaded_Q_vector),
        .raddr (rd_ptr),
        .rdata (rdata0)
    );

    q_tile_bank #(.ROWS(Q_ROWS)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire && wr_bank),
        .waddr (wr_ptr),
        .wdata (loaded_Q_vector),
        .raddr (rd_ptr),
        .rdata (rdata1)
    );

    assign q_vector   = rd_bank ? rdata1 : rdata0;
    assign q_row_idx  = rd_ptr;
    assign q_pass_idx = pass_cnt;
    assign tile_done  = done_q;

    // Fill-complete and free always target different banks (writes need an
    // empty bank, reads a full one), so both can land in the same cycle.
    always_comb begin
        bank_full_next = bank_full;
        if (wr_fire && wr_last) begin
            bank_full_next[wr_bank] = 1'b1;
        end
        if (tile_free) begin
            bank_full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pass_cnt  <= '0;
            done_q    <= 1'b0;
        end else begin
            bank_full <= bank_full_next;
            done_q    <= tile_free;

            if (wr_fire) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + ROW_W'(1);
                end
            end

            if (rd_fire) begin
                if (rd_row_last) begin
                    rd_ptr <= '0;
                    if (pass_last) begin
                        pass_cnt <= '0;
                        rd_bank  <= ~rd_bank;
                    end else begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                    end
                end else begin
                    rd_ptr <= rd_ptr + ROW_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_q_tile_buffer.sv
// Directed bench for q_tile_buffer with Q_ROWS=4, KV_PASSES=2: a cycle table for
// the first tile plus hand-written ping-pong, backpressure, gap and reset sequences.
module tb_q_tile_buffer;
    import q_tile_buffer_pkg::*;

    localparam int ROWS   = 4;
    localparam int PASSES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_vld;
    logic [15:0] loaded_Q_vector;
    logic        Q_sram_rdy;
    logic        q_vld;
    logic [15:0] q_vector;
    logic [1:0]  q_row_idx;
    logic        q_pass_idx;
    logic        pe_rdy;
    logic        tile_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic        cv;
        logic [15:0] data;
        logic        pr;
        logic        e_rdy;
        logic        e_vld;
        logic [15:0] e_vec;
        logic [1:0]  e_row;
        logic        e_pass;
        logic        e_done;
    } vec_t;

    vec_t tbl [14];

    q_tile_buffer #(.Q_ROWS(ROWS), .KV_PASSES(PASSES)) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_vld        (ctrl_vld),
        .loaded_Q_vector (loaded_Q_vector),
        .Q_sram_rdy      (Q_sram_rdy),
        .q_vld           (q_vld),
        .q_vector        (q_vector),
        .q_row_idx       (q_row_idx),
        .q_pass_idx      (q_pass_idx),
        .pe_rdy          (pe_rdy),
        .tile_done       (tile_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic cv, logic [15:0] d, logic pr, logic e_rdy, logic e_vld,
                                logic [15:0] e_vec, logic [1:0] e_row, logic e_pass, logic e_done);
        vec_t v;
        v.cv = cv;  v.data = d;  v.pr = pr;
        v.e_rdy = e_rdy;  v.e_vld = e_vld;  v.e_vec = e_vec;
        v.e_row = e_row;  v.e_pass = e_pass;  v.e_done = e_done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input string tag, input logic e_rdy, input logic e_vld,
                                input logic [15:0] e_vec, input logic [1:0] e_row,
                                input logic e_pass, input logic e_done);
        check({tag, ".rdy"},  32'(Q_sram_rdy), 32'(e_rdy));
        check({tag, ".vld"},  32'(q_vld),      32'(e_vld));
        check({tag, ".vec"},  32'(q_vector),   32'(e_vec));
        check({tag, ".row"},  32'(q_row_idx),  32'(e_row));
        check({tag, ".pass"}, 32'(q_pass_idx), 32'(e_pass));
        check({tag, ".done"}, 32'(tile_done),  32'(e_done));
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic apply_stimulus(input logic cv, input logic [15:0] d, input logic pr);
        @(negedge clk);
        ctrl_vld        = cv;
        loaded_Q_vector = d;
        pe_rdy          = pr;
        #1;
    endtask

    task automatic replay_check(input string tag, input logic [15:0] base);
        for (int f = 0; f < ROWS * PASSES; f++) begin
            apply_stimulus(1'b0, 16'h0, 1'b1);
            check({tag, ".vld"},  32'(q_vld),      32'd1);
            check({tag, ".vec"},  32'(q_vector),   32'(base + 16'(f % ROWS)));
            check({tag, ".row"},  32'(q_row_idx),  32'(f % ROWS));
            check({tag, ".pass"}, 32'(q_pass_idx), 32'(f / ROWS));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fires;
        int row;
        int pass;
        int cyc;
        logic pr;

        rst             = 1'b0;
        ctrl_vld        = 1'b0;
        loaded_Q_vector = 16'h0;
        pe_rdy          = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_output("reset", 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;

        // Single tile, PE always ready: four writes, then two passes, then tile_done.
        tbl[0]  = mk(1, 16'hA0, 1,  1, 0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(1, 16'hA1, 1,  1, 0, 16'h00A0, 0, 0, 0);
        tbl[2]  = mk(1, 16'hA2, 1,  1, 0, 16'h00A0, 0, 0, 0);
        tbl[3]  = mk(1, 16'hA3, 1,  1, 0, 16'h00A0, 0, 0, 0);
        tbl[4]  = mk(0, 16'h00, 1,  1, 1, 16'h00A0, 0, 0, 0);
        tbl[5]  = mk(0, 16'h00, 1,  1, 1, 16'h00A1, 1, 0, 0);
        tbl[6]  = mk(0, 16'h00, 1,  1, 1, 16'h00A2, 2, 0, 0);
        tbl[7]  = mk(0, 16'h00, 1,  1, 1, 16'h00A3, 3, 0, 0);
        tbl[8]  = mk(0, 16'h00, 1,  1, 1, 16'h00A0, 0, 1, 0);
        tbl[9]  = mk(0, 16'h00, 1,  1, 1, 16'h00A1, 1, 1, 0);
        tbl[10] = mk(0, 16'h00, 1,  1, 1, 16'h00A2, 2, 1, 0);
        tbl[11] = mk(0, 16'h00, 1,  1, 1, 16'h00A3, 3, 1, 0);
        tbl[12] = mk(0, 16'h00, 1,  1, 0, 16'h0000, 0, 0, 1);
        tbl[13] = mk(0, 16'h00, 1,  1, 0, 16'h0000, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i].cv, tbl[i].data, tbl[i].pr);
            check_output($sformatf("tbl%0d", i), tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_vec,
                         tbl[i].e_row, tbl[i].e_pass, tbl[i].e_done);
        end

        // Upstream gaps into bank 1: q_vld must rise only after the fourth write lands.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus((i % 2) == 0, 16'hD0 + 16'(i / 2), 1'b0);
            check($sformatf("gap%0d.vld", i), 32'(q_vld), (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("gap%0d.rdy", i), 32'(Q_sram_rdy), 32'd1);
        end
        replay_check("gap_replay", 16'hD0);
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check("gap.done", 32'(tile_done), 32'd1);
        check("gap.vld_off", 32'(q_vld), 32'd0);

        // Ping-pong: fill both banks with PE stalled, then offer C0 that must be refused.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, (i < 4) ? 16'hA0 + 16'(i) : 16'hB0 + 16'(i - 4), 1'b0);
            check($sformatf("pp_fill%0d.rdy", i), 32'(Q_sram_rdy), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 16'hC0, 1'b0);
            check_output($sformatf("pp_full%0d", k), 1'b0, 1'b1, 16'hA0, 2'd0, 1'b0, 1'b0);
        end
        for (int f = 0; f < 8; f++) begin
            apply_stimulus(1'b0, 16'h0, 1'b1);
            check_output($sformatf("pp_a%0d", f), 1'b0, 1'b1, 16'hA0 + 16'(f % 4),
                         2'(f % 4), 1'(f / 4), 1'b0);
        end
        for (int f = 0; f < 8; f++) begin
            apply_stimulus(1'b0, 16'h0, 1'b1);
            check_output($sformatf("pp_b%0d", f), 1'b1, 1'b1, 16'hB0 + 16'(f % 4),
                         2'(f % 4), 1'(f / 4), (f == 0));
        end
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check("pp.done", 32'(tile_done), 32'd1);
        check("pp.vld_off", 32'(q_vld), 32'd0);

        // Random backpressure on a tile in bank 0: the model advances only on a fire.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 16'hE0 + 16'(i), 1'b0);
        end
        fires = 0;  row = 0;  pass = 0;  cyc = 0;
        while (fires < 8 && cyc < 200) begin
            pr = 1'($urandom_range(0, 1));
            apply_stimulus(1'b0, 16'h0, pr);
            check("bp.vld",  32'(q_vld),      32'd1);
            check("bp.vec",  32'(q_vector),   32'(16'hE0 + 16'(row)));
            check("bp.row",  32'(q_row_idx),  32'(row));
            check("bp.pass", 32'(q_pass_idx), 32'(pass));
            check("bp.done", 32'(tile_done),  32'd0);
            if (pr) begin
                fires++;
                row++;
                if (row == ROWS) begin
                    row = 0;
                    pass++;
                end
            end
            cyc++;
        end
        if (fires < 8) check("bp.timeout_fires", 32'(fires), 32'd8);
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check("bp.done_pulse", 32'(tile_done), 32'd1);
        check("bp.vld_off", 32'(q_vld), 32'd0);

        // Reset during pass 1, row 2, then a fresh tile must start from row 0, pass 0.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 16'hF0 + 16'(i), 1'b0);
        end
        for (int f = 0; f < 6; f++) begin
            apply_stimulus(1'b0, 16'h0, 1'b1);
        end
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check_output("pre_rst", 1'b1, 1'b1, 16'hF2, 2'd2, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_output("mid_rst", 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_output("mid_rst_hold", 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 16'h11 + 16'(i), 1'b0);
        end
        replay_check("post_rst", 16'h11);
        apply_stimulus(1'b0, 16'h0, 1'b0);
        check("post_rst.done", 32'(tile_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
